// File: rtl/uart_packet_scheduler.sv
// uart_packet_scheduler: round-robin arbiter that latches one source's payload and frames it
// as HEADER, source ID, payload (MSB first), checksum onto a byte-wide UART handshake.
module uart_packet_scheduler #(
    parameter int         NUM_SRC       = 3,
    parameter int         PAYLOAD_BYTES = 2,
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter int         BUSY_TIMEOUT  = 1024
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_SRC-1:0]                   req,
    input  logic [NUM_SRC*8*PAYLOAD_BYTES-1:0]   payload,
    output logic [NUM_SRC-1:0]                   ack,
    output logic                                 uart_data_rdy,
    output logic [7:0]                           uart_data,
    input  logic                                 tx_busy,
    output logic                                 sched_busy,
    output logic                                 timeout_err
);
    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [2:0] LAST = 3'(PAYLOAD_BYTES + 2);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      rr_q, rr_d, src_q, src_d, grant;
    logic [PW-1:0]      pay_q, pay_d;
    logic [2:0]         idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic               rdy_q, rdy_d, busy_q, err_q, err_d, found;
    logic [7:0]         data_q, data_d, csum, cur;
    int                 j;

    // First requester at or after rr_q, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        j = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_SRC) j -= NUM_SRC;
            if (!found && req[SW'(j)]) begin
                grant = SW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        csum = 8'(src_q);
        for (int k = 0; k < PAYLOAD_BYTES; k++) csum = csum + pay_q[8*k +: 8];
        cur = idx_q == 3'd0 ? HEADER : idx_q == 3'd1 ? 8'(src_q) : csum;
        for (int k = 0; k < PAYLOAD_BYTES; k++)
            if (idx_q == 3'(k + 2)) cur = pay_q[PW-8-8*k +: 8];
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        pay_d   = pay_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        rdy_d   = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = SEND;
                src_d   = grant;
                pay_d   = payload[grant*PW +: PW];
                ack_d   = NUM_SRC'(1) << grant;
                idx_d   = '0;
                rr_d    = grant == SW'(NUM_SRC - 1) ? '0 : grant + 1'b1;
            end
            SEND: if (!tx_busy) begin
                state_d = WAIT_HI;
                rdy_d   = 1'b1;
                data_d  = cur;
                cnt_d   = '0;
            end
            // The counter stops at BUSY_TIMEOUT because that exits the state.
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
                else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else cnt_d = cnt_q + 1'b1;
            WAIT_LO: if (!tx_busy) state_d = NEXT;
            NEXT: begin
                state_d = idx_q == LAST ? IDLE : SEND;
                idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            src_q   <= '0;
            pay_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            pay_q   <= pay_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            busy_q  <= state_d != IDLE;
            err_q   <= err_d;
        end
    end

    assign ack           = ack_q;
    assign uart_data_rdy = rdy_q;
    assign uart_data     = data_q;
    assign sched_busy    = busy_q;
    assign timeout_err   = err_q;
endmodule
